// File: rtl/hex_display_latch_pkg.sv
// Shared constants for the hex display latch: field widths and
// active-low gfedcba segment codes.
package hex_display_pkg;

    localparam int NIB_W = 4;
    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG_A     = 7'h08;
    localparam logic [SEG_W-1:0] SEG_B     = 7'h03;
    localparam logic [SEG_W-1:0] SEG_C     = 7'h46;
    localparam logic [SEG_W-1:0] SEG_D     = 7'h21;
    localparam logic [SEG_W-1:0] SEG_E     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_F     = 7'h0E;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/hex_display_latch_if.sv
// Switch/key inputs and display outputs of the hex display latch.
// master drives the inputs, slave is the display controller.
interface hex_display_latch_if #(
    parameter int NUM_DIGITS = 8
);

    logic                      key_load_n;
    logic [4*NUM_DIGITS-1:0]   value_in;
    logic [NUM_DIGITS-1:0]     blink_mask;
    logic                      blank_lz;
    logic [7*NUM_DIGITS-1:0]   hex_seg;
    logic [4*NUM_DIGITS-1:0]   shown_value;
    logic                      load_pulse;
    logic                      heartbeat;

    modport master (
        output key_load_n, value_in, blink_mask, blank_lz,
        input  hex_seg, shown_value, load_pulse, heartbeat
    );

    modport slave (
        input  key_load_n, value_in, blink_mask, blank_lz,
        output hex_seg, shown_value, load_pulse, heartbeat
    );

endinterface

// File: rtl/hex_seg_decoder.sv
// Combinational nibble to active-low seven-segment decode.
// Bit order of seg is {g,f,e,d,c,b,a}.
module hex_seg_decoder
    import hex_display_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/hex_display_latch.sv
// N-digit seven-segment controller: debounced key latches value_in,
// digits support per-digit blinking and leading-zero blanking.
module hex_display_latch
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS      = 8,
    parameter int PRESCALE_BITS   = 26,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic          CLOCK_50,
    input  logic          RESET_N,
    hex_display_latch_if.slave bus
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    logic                          sync1, sync2;
    logic                          key_state;
    logic [DB_W-1:0]               db_cnt;
    logic                          db_hit;
    logic                          load_q;
    logic [PRESCALE_BITS-1:0]      presc;
    logic [NIB_W*NUM_DIGITS-1:0]   shown;
    logic [SEG_W*NUM_DIGITS-1:0]   seg_q, seg_nxt;
    logic [NUM_DIGITS-1:0][SEG_W-1:0] dec;
    logic                          zero_run;
    logic                          lz, blink;

    // Accept a level only after it has differed for DEBOUNCE_CYCLES cycles.
    assign db_hit = (sync2 != key_state) && (db_cnt == DB_MAX);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            key_state <= 1'b1;
            db_cnt    <= '0;
            load_q    <= 1'b0;
        end else begin
            sync1  <= bus.key_load_n;
            sync2  <= sync1;
            load_q <= db_hit & key_state;
            if (sync2 == key_state) begin
                db_cnt <= '0;
            end else if (db_hit) begin
                db_cnt    <= '0;
                key_state <= ~key_state;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            presc <= '0;
            shown <= '0;
            seg_q <= '1;
        end else begin
            presc <= presc + 1'b1;
            seg_q <= seg_nxt;
            if (load_q) shown <= bus.value_in;
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
        hex_seg_decoder u_dec (
            .nibble (shown[NIB_W*i +: NIB_W]),
            .seg    (dec[i])
        );
    end

    // Walk from the top digit down so zero_run means "this and all above are 0".
    always_comb begin
        seg_nxt  = '1;
        zero_run = 1'b1;
        lz       = 1'b0;
        blink    = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (shown[NIB_W*i +: NIB_W] == 4'h0);
            lz       = bus.blank_lz & zero_run & (i != 0);
            blink    = bus.blink_mask[i] & presc[PRESCALE_BITS-1];
            seg_nxt[SEG_W*i +: SEG_W] = (lz | blink) ? SEG_BLANK : dec[i];
        end
    end

    assign bus.hex_seg     = seg_q;
    assign bus.shown_value = shown;
    assign bus.load_pulse  = load_q;
    assign bus.heartbeat   = presc[PRESCALE_BITS-1];

endmodule

// File: doc/hex_display_latch.md
Name: hex_display_latch

Overview:
- Parametrised N-digit seven-segment display controller for the DE2 board.
- Latches a packed hex value from switches/register wires on a debounced pushbutton press, then holds it independent of later input changes.
- Adds per-digit blinking driven by a free-running prescaler, and optional leading-zero blanking.
- Sits between datapath/switch wiring and the HEX0..HEX7 pins; the top level slices the packed hex_seg bus onto the individual HEX ports.

Parameters:
- NUM_DIGITS, 8, number of hex digits driven (1..8).
- PRESCALE_BITS, 26, width of the free-running counter; blink phase is counter[PRESCALE_BITS-1].
- DEBOUNCE_CYCLES, 500000, cycles a raw key level must stay stable before it is accepted (>=2).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- RESET_N  in  1  asynchronous active-low reset.
- key_load_n  in  1  raw active-low pushbutton, asynchronous to CLOCK_50.
- value_in  in  4*NUM_DIGITS  packed nibbles; digit i = value_in[4i+3:4i].
- blink_mask  in  NUM_DIGITS  bit i=1 makes digit i blink.
- blank_lz  in  1  1 = blank leading zero digits.
- hex_seg  out  7*NUM_DIGITS  active-low segments {g,f,e,d,c,b,a} per digit; digit i = hex_seg[7i+6:7i].
- shown_value  out  4*NUM_DIGITS  currently latched value.
- load_pulse  out  1  one-cycle strobe per accepted press.
- heartbeat  out  1  blink phase (counter MSB), for an LED.

Behaviour:
- Reset (async assert, sync release):
  - shown_value=0, load_pulse=0, heartbeat=0, prescaler=0, debounce counter=0.
  - Synchronizer flops=1; debounced key state=released (1).
  - hex_seg all 1s, i.e. every digit dark.
- Synchronizer: 2-flop on key_load_n; all later logic uses the synced level only.
- Debounce:
  - Counter clears whenever the synced level equals the accepted state.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 while the level still differs, the accepted state toggles and the counter clears.
  - Any bounce back to the accepted level before that clears the counter.
- Press detect:
  - Accepted state 1->0 asserts load_pulse for exactly one cycle.
  - A 0->1 release produces no pulse.
  - Holding the key gives one pulse only.
- Latch:
  - On the edge where load_pulse=1, shown_value <= value_in sampled at that edge.
  - shown_value is visible the cycle after load_pulse.
- Prescaler:
  - Free-running, wraps from 2^PRESCALE_BITS-1 to 0.
  - heartbeat = MSB, registered with the counter.
- Blanking (evaluated per digit on current shown_value and phase):
  - lz_i = blank_lz & (all nibbles i..NUM_DIGITS-1 are 0) & (i != 0). Digit 0 is never LZ-blanked.
  - blink_i = blink_mask[i] & heartbeat.
  - Digit i is dark (7'h7F) if lz_i | blink_i; otherwise it shows the decoded nibble 0-F.
- Segment codes, gfedcba active-low: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
- hex_seg is registered: one cycle after any change of shown_value, heartbeat, blink_mask or blank_lz.
- Overall latency from accepted press to new digits on hex_seg: 2 cycles after load_pulse edge.
- Simultaneous events:
  - A load on the same edge as a phase toggle applies both; the next hex_seg reflects the new value and the new phase.
  - value_in changes outside load_pulse are ignored.
- Reset mid-debounce or with the key held:
  - State returns to released.
  - A key still held after reset release is accepted as a new press after DEBOUNCE_CYCLES+2 cycles.
- value_in, blink_mask and blank_lz are synchronous to CLOCK_50; the block does not synchronize them.

Decomposition:
- Package hex_display_pkg: SEG_0..SEG_F constants, SEG_BLANK=7'h7F, nibble width 4, segment width 7.
- Sub-module hex_seg_decoder: combinational 4-bit to 7-bit active-low decode, instantiated NUM_DIGITS times via generate.
- Synchronizer, debounce, prescaler and latch stay in the top block.

Test Plan (NUM_DIGITS=4, PRESCALE_BITS=4, DEBOUNCE_CYCLES=4):
1. Reset: hold RESET_N=0 with key high -> hex_seg=28'hFFFFFFF, shown_value=0, load_pulse=0. Release, blink_mask=0, blank_lz=0 -> hex_seg = four 7'h40 one cycle later.
2. Clean press: value_in=16'h1A2F, key low held 10 cycles -> single load_pulse about 6 cycles after the fall. shown_value=1A2F next cycle. Digits 3..0 = 79,08,24,0E two cycles after the pulse. Releasing the key gives no pulse.
3. Bounce: toggle key low/high every 2 cycles for 20 cycles -> no load_pulse, shown_value unchanged. Then hold low -> exactly one pulse.
4. Leading zero: latch 16'h0030, blank_lz=1 -> digits 3,2 dark, digit1=30, digit0=40. Latch 16'h0000 -> digits 3..1 dark, digit0=40.
5. Blink: blink_mask=4'b0101, latched 16'h1234 -> digits 0 and 2 alternate between decoded and 7F every 8 cycles, in phase with heartbeat; digits 1 and 3 steady.
6. Reset mid-debounce: key low 2 cycles, assert RESET_N, release with key still low -> no pulse during reset; one pulse DEBOUNCE_CYCLES+2 cycles after reset release.
